// File: rtl/alu_sequencer.sv
// alu_sequencer: feeds an external 8-bit combinational ALU from a valid/ready
// command stream and returns each captured result as a valid/ready response.
// Each command runs through three states: IDLE accepts it, EXEC drives the ALU
// for one full cycle, and RESP holds the response until it is consumed.
// An internal accumulator can supply operand A and can receive the result.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             cmd_wb,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   wb_flag;
    logic   err_flag;

    // Sequencer FSM: all outputs are registered, so every output is held steady between edges.
    // NOTE: every register in this block is assigned with <=, so each branch reads the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            alu_opcode <= '0;
            alu_in_a   <= '0;
            alu_in_b   <= '0;
            wb_flag    <= 1'b0;
            err_flag   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            acc        <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        // The drive registers change only here, so the ALU inputs are stable through EXEC and RESP.
                        alu_opcode <= cmd_op;
                        alu_in_a   <= cmd_use_acc ? acc : cmd_a;
                        alu_in_b   <= cmd_b;
                        wb_flag    <= cmd_wb;
                        err_flag   <= (cmd_op == 4'h0) || (cmd_op > 4'hB);
                        cmd_ready  <= 1'b0;
                        state      <= EXEC;
                    end else begin
                        // cmd_ready comes up one cycle after reset is released.
                        cmd_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    if (err_flag) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_zero  <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        rsp_data  <= alu_result;
                        rsp_carry <= alu_cout;
                        // Zero is taken from the 8-bit result, so a wrap such as FF+01 reports zero.
                        rsp_zero  <= (alu_result == '0);
                        rsp_err   <= 1'b0;
                        if (wb_flag) begin
                            acc <= alu_result;
                        end
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: models the ALU combinationally and scoreboards every
// response against a reference model of the command stream
// (accumulator value, completed-operation count).
module tb_alu_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic             cmd_wb;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_acc;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .cmd_wb      (cmd_wb),
        .alu_opcode  (alu_opcode),
        .alu_in_a    (alu_in_a),
        .alu_in_b    (alu_in_b),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .acc         (acc),
        .op_count    (op_count)
    );

    // Behavioural ALU: bit 8 is the carry (borrow for sub/dec/negate, shifted-out bit for shifts).
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h1:    return {1'b0, a} + {1'b0, b};
            4'h2:    return {1'b0, a} - {1'b0, b};
            4'h3:    return {1'b0, a} + 9'd1;
            4'h4:    return {1'b0, a} - 9'd1;
            4'h5:    return {1'b0, a | b};
            4'h6:    return {1'b0, a & b};
            4'h7:    return {1'b0, a ^ b};
            4'h8:    return {a[0], 1'b0, a[7:1]};
            4'h9:    return {a, 1'b0};
            4'hA:    return {1'b0, ~a};
            4'hB:    return 9'd0 - {1'b0, a};
            default: return 9'h0AA;
        endcase
    endfunction

    logic [8:0] alu_full;
    assign alu_full   = alu_f(alu_opcode, alu_in_a, alu_in_b);
    assign alu_result = alu_full[7:0];
    assign alu_cout   = alu_full[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command at a negedge and follows it to completion; rsp_ready stays low for hold cycles.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input logic wb, input int hold,
                          output logic [7:0] got_data);
        int         n;
        logic [7:0] a_eff;
        logic [8:0] full;
        logic       err;
        logic [7:0] e_data;
        logic       e_carry;
        logic       e_zero;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 20), 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_wb      = wb;
        a_eff       = use_acc ? m_acc : a;
        err         = (op == 4'h0) || (op > 4'hB);
        full        = alu_f(op, a_eff, b);
        e_data      = err ? 8'h00 : full[7:0];
        e_carry     = err ? 1'b0 : full[8];
        e_zero      = (e_data == 8'h00);
        @(negedge clk);
        // EXEC cycle
        cmd_valid = 1'b0;
        cmd_a     = $urandom_range(255, 0);
        cmd_b     = $urandom_range(255, 0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_alu_opcode", 32'(alu_opcode), 32'(op));
        check("exec_alu_in_a", 32'(alu_in_a), 32'(a_eff));
        check("exec_alu_in_b", 32'(alu_in_b), 32'(b));
        @(negedge clk);
        // RESP cycle
        if (wb && !err) m_acc = full[7:0];
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(e_data));
        check("rsp_carry", 32'(rsp_carry), 32'(e_carry));
        check("rsp_zero", 32'(rsp_zero), 32'(e_zero));
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_acc", 32'(acc), 32'(m_acc));
        got_data = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_rsp_data", 32'(rsp_data), 32'(e_data));
            check("hold_rsp_err", 32'(rsp_err), 32'(err));
            check("hold_op_count", 32'(op_count), 32'(m_count));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_count   = m_count + 16'd1;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_op_count", 32'(op_count), 32'(m_count));
        check("done_cmd_ready", 32'(cmd_ready), 32'd1);
        check("done_acc", 32'(acc), 32'(m_acc));
    endtask

    logic [7:0] d;

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'h0;
        cmd_a       = 8'h00;
        cmd_b       = 8'h00;
        cmd_use_acc = 1'b0;
        cmd_wb      = 1'b0;
        rsp_ready   = 1'b0;
        m_acc       = 8'h00;
        m_count     = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_in_a", 32'(alu_in_a), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed: add, carry wrap, borrow
        do_cmd(4'h1, 8'h12, 8'h34, 1'b0, 1'b0, 0, d);
        check("add_data", 32'(d), 32'h46);
        do_cmd(4'h1, 8'hFF, 8'h01, 1'b0, 1'b0, 0, d);
        check("wrap_data", 32'(d), 32'h00);
        do_cmd(4'h2, 8'h05, 8'h06, 1'b0, 1'b0, 0, d);
        check("borrow_data", 32'(d), 32'hFF);

        // Accumulator chain
        do_cmd(4'h1, 8'h10, 8'h05, 1'b0, 1'b1, 0, d);
        check("chain_acc1", 32'(acc), 32'h15);
        do_cmd(4'h3, 8'h00, 8'h00, 1'b1, 1'b1, 0, d);
        check("chain_acc2", 32'(acc), 32'h16);
        do_cmd(4'h9, 8'h00, 8'h00, 1'b1, 1'b1, 0, d);
        check("chain_acc3", 32'(acc), 32'h2C);
        check("chain_data3", 32'(d), 32'h2C);

        // Illegal opcode with backpressure; acc must not change
        do_cmd(4'hC, 8'h77, 8'h11, 1'b0, 1'b1, 5, d);
        check("illegal_acc", 32'(acc), 32'h2C);

        // Randomized commands against the model
        for (int k = 0; k < 40; k++) begin
            do_cmd(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom_range(3, 0), d);
        end
        // Guarantee a nonzero accumulator before the reset test
        do_cmd(4'h1, 8'h40, 8'h01, 1'b0, 1'b1, 0, d);

        // Reset during EXEC of a wb command
        cmd_valid   = 1'b1;
        cmd_op      = 4'h1;
        cmd_a       = 8'h21;
        cmd_b       = 8'h03;
        cmd_use_acc = 1'b0;
        cmd_wb      = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        m_acc   = 8'h00;
        m_count = 16'h0000;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_idle_valid", 32'(rsp_valid), 32'd0);
        do_cmd(4'h7, 8'h5A, 8'h0F, 1'b0, 1'b1, 1, d);
        check("after_rst_data", 32'(d), 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Drives the 8-bit combinational ALU from a command stream. It accepts one command per valid/ready handshake, presents registered operands and opcode to the ALU, and captures the ALU result and carry. It returns them as a response with a valid/ready handshake, and optionally writes the result back to an internal accumulator.
- Sits between the control/decode logic and the ALU instance, and is the only driver of the ALU inputs.

## Interface

- WIDTH, 8, datapath width; must equal the ALU width (8).
- CNT_W, 16, width of the completed-operation counter.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  ALU opcode: 1 add, 2 sub, 3 inc, 4 dec, 5 or, 6 and, 7 xor, 8 shr, 9 shl, A ones-comp, B twos-comp.
- cmd_a  in  WIDTH  operand A (ignored when cmd_use_acc=1).
- cmd_b  in  WIDTH  operand B.
- cmd_use_acc  in  1  1: operand A comes from the accumulator.
- cmd_wb  in  1  1: write the result back to the accumulator.
- alu_opcode  out  4  to ALU opcode.
- alu_in_a  out  WIDTH  to ALU in_a.
- alu_in_b  out  WIDTH  to ALU in_b.
- alu_result  in  WIDTH  from ALU alu_out.
- alu_cout  in  1  from ALU alu_carry.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zero  out  1  1 when rsp_data == 0.
- rsp_err  out  1  illegal opcode (0, C–F).
- acc  out  WIDTH  accumulator value.
- op_count  out  CNT_W  number of completed responses; wraps to 0.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1, latch the following into the drive registers and go to EXEC:
    - alu_opcode ← cmd_op;
    - alu_in_a ← (cmd_use_acc ? acc : cmd_a);
    - alu_in_b ← cmd_b;
    - the wb flag;
    - the err flag = (cmd_op==0 or cmd_op>0xB).
- EXEC:
  - ALU inputs are stable for the full cycle.
  - At the end of the cycle, capture into the response registers:
    - rsp_data ← alu_result;
    - rsp_carry ← alu_cout;
    - rsp_zero ← (alu_result==0).
  - If err=1, the capture is instead: rsp_data=0, rsp_carry=0, rsp_zero=1, rsp_err=1.
  - If wb=1 and err=0, acc ← alu_result in the same edge.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable.
  - When rsp_ready=1: op_count increments (wraps at 2^CNT_W−1 → 0), then go to IDLE.
  - rsp_valid deasserts the cycle after the handshake.
- cmd_ready=0 in EXEC and RESP; commands are never dropped, they wait.
- The alu_zero output of the ALU is not used. Zero is computed locally from the 8-bit result, so a carry-out wrap such as FF+01 gives rsp_zero=1.
- Carry for sub/dec is the ALU's bit 8: 1 on borrow.
- The drive registers hold their last values in IDLE and RESP; they change only on command acceptance.

## Timing

- Accept edge T (cmd_valid & cmd_ready). EXEC during cycle T+1. rsp_valid=1 from cycle T+2.
- Latency from accept to rsp_valid is 2 cycles.
- Minimum command period is 3 cycles (accept, EXEC, RESP with rsp_ready=1). IDLE is always revisited, so there is no accept in RESP.
- A use_acc command issued directly after a wb command sees the updated accumulator: the wb occurs at the end of EXEC, before the next IDLE.
- rsp_ready held low keeps the block in RESP indefinitely with all outputs stable.
- Reset, when reset=1 at an edge, from any state:
  - state → IDLE;
  - acc, alu_opcode, alu_in_a, alu_in_b, rsp_data, rsp_carry, rsp_zero, rsp_err, rsp_valid, op_count → 0;
  - any in-flight command or response is discarded.
- cmd_ready is forced to 0 while reset=1 and returns to 1 the cycle after reset deasserts.
- rsp_valid never asserts without a preceding accept.

## Test plan

- Reset, then add: cmd_op=1, a=0x12, b=0x34, wb=0, rsp_ready=1.
  - rsp_valid 2 cycles after accept.
  - rsp_data=0x46, carry=0, zero=0, err=0.
  - op_count=1; acc=0.
- Carry wrap: cmd_op=1, a=0xFF, b=0x01 → rsp_data=0x00, carry=1, zero=1.
- Borrow: cmd_op=2, a=0x05, b=0x06 → rsp_data=0xFF, carry=1, zero=0.
- Accumulator chain, each command accepted as soon as cmd_ready rises:
  - add a=0x10, b=0x05, wb=1 → acc=0x15;
  - inc use_acc=1, wb=1 → acc=0x16;
  - shl use_acc=1, wb=1 → acc=0x2C, rsp_data=0x2C.
- Backpressure and illegal opcode:
  - cmd_op=0xC, wb=1, rsp_ready=0 for 5 cycles → rsp_valid held with rsp_err=1, data=0, zero=1; cmd_ready=0 throughout; acc unchanged.
  - After rsp_ready=1: op_count increments and cmd_ready returns.
- Reset mid-operation: assert reset in the EXEC cycle of a wb command → next cycle rsp_valid=0, acc=0, op_count=0, state IDLE; the next command completes normally.
